// File: rtl/opb_status_bank_pkg.sv
// Shared constants and helpers for the OPB status bank: word map offsets and bus bit ordering.
package opb_status_bank_pkg;

   localparam int unsigned STATUS_W = 32;

   function automatic int unsigned pending_word(input int unsigned n);
      return n;
   endfunction

   function automatic int unsigned irq_en_word(input int unsigned n);
      return n + 1;
   endfunction

   function automatic int unsigned ts_base_word(input int unsigned n);
      return n + 2;
   endfunction

   // OPB numbers bits MSB-first: DBus[k] carries register bit 31-k.
   function automatic logic [STATUS_W-1:0] bus_to_reg(input logic [0:STATUS_W-1] d);
      logic [STATUS_W-1:0] r;
      for (int unsigned k = 0; k < STATUS_W; k++) r[STATUS_W-1-k] = d[k];
      return r;
   endfunction

   function automatic logic [0:STATUS_W-1] reg_to_bus(input logic [STATUS_W-1:0] r);
      logic [0:STATUS_W-1] d;
      for (int unsigned k = 0; k < STATUS_W; k++) d[k] = r[STATUS_W-1-k];
      return d;
   endfunction

endpackage

// File: rtl/opb_status_chan.sv
// One status channel: sample capture, sticky accumulate with W1C, pending flag.
// OPB_STATUS_BANK_TIMESTAMP_EN adds a timestamp latched on any bit change.
module opb_status_chan
   import opb_status_bank_pkg::*;
#(
   parameter logic [STATUS_W-1:0] STICKY_MASK = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic [STATUS_W-1:0] din,
   input  logic                clr_en,
   input  logic [STATUS_W-1:0] clr_data,
   input  logic [STATUS_W-1:0] clr_mask,
`ifdef OPB_STATUS_BANK_TIMESTAMP_EN
   input  logic [STATUS_W-1:0] ts_now,
   output logic [STATUS_W-1:0] ts,
`endif
   output logic [STATUS_W-1:0] status,
   output logic                pending_c
);

   logic [STATUS_W-1:0] clr_bits;
   logic [STATUS_W-1:0] status_next;

   // Clear is applied first so a same-cycle set on a sticky bit survives.
   always_comb begin
      clr_bits    = clr_en ? (STICKY_MASK & clr_mask & clr_data) : '0;
      status_next = status & ~clr_bits;
      if (valid) status_next = (din & ~STICKY_MASK) | ((status_next | din) & STICKY_MASK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) status <= '0;
      else     status <= status_next;
   end

   assign pending_c = |(status & STICKY_MASK);

`ifdef OPB_STATUS_BANK_TIMESTAMP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 ts <= '0;
      else if (valid && status_next != status) ts <= ts_now;
   end
`endif

endmodule

// File: rtl/opb_status_bank.sv
// Multi-channel OPB status register bank with sticky/W1C bits, pending summary and maskable irq.
// Define OPB_STATUS_BANK_TIMESTAMP_EN to add a cycle counter and per-channel timestamp words.
module opb_status_bank
   import opb_status_bank_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR    = 32'h0100_2100,
   parameter logic [31:0] C_HIGHADDR    = 32'h0100_21FF,
   parameter int unsigned C_OPB_AWIDTH  = 32,
   parameter int unsigned C_OPB_DWIDTH  = 32,
   parameter int unsigned C_NUM_CH      = 4,
   parameter logic [31:0] C_STICKY_MASK = 32'h0000_0000
) (
   input  logic                         OPB_Clk,
   input  logic                         OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1]    OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
   input  logic                         OPB_RNW,
   input  logic                         OPB_select,
   input  logic                         OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
   output logic                         Sl_xferAck,
   output logic                         Sl_errAck,
   output logic                         Sl_retry,
   output logic                         Sl_toutSup,
   input  logic [C_NUM_CH*STATUS_W-1:0] user_data_in,
   input  logic [C_NUM_CH-1:0]          user_valid,
   output logic                         irq
);

   localparam int unsigned AW = C_OPB_AWIDTH;

   logic                hit;
   logic                start;
   logic                wr;
   logic [AW-1:0]       offset;
   logic [AW-1:0]       word;
   logic [STATUS_W-1:0] wdata;
   logic [STATUS_W-1:0] wmask;
   logic [STATUS_W-1:0] rdata;
   logic [STATUS_W-1:0] status [C_NUM_CH];
   logic [C_NUM_CH-1:0] pending;
   logic [C_NUM_CH-1:0] irq_en;
   logic [C_NUM_CH-1:0] chan_wr;
   logic                unused_seq;

   assign unused_seq = OPB_seqAddr;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   assign hit    = (OPB_ABus >= AW'(C_BASEADDR)) && (OPB_ABus <= AW'(C_HIGHADDR));
   assign start  = OPB_select & hit & ~Sl_xferAck;
   assign wr     = start & ~OPB_RNW;
   assign offset = OPB_ABus - AW'(C_BASEADDR);
   assign word   = offset >> 2;
   assign wdata  = bus_to_reg(OPB_DBus);

   // BE[0] covers the most significant register byte.
   for (genvar b = 0; b < 4; b++) begin : g_be
      assign wmask[8*b +: 8] = {8{OPB_BE[3-b]}};
   end

`ifdef OPB_STATUS_BANK_TIMESTAMP_EN
   logic [STATUS_W-1:0] ts_count;
   logic [STATUS_W-1:0] ts [C_NUM_CH];

   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) ts_count <= '0;
      else         ts_count <= ts_count + STATUS_W'(1);
   end
`endif

   for (genvar i = 0; i < C_NUM_CH; i++) begin : g_chan
      assign chan_wr[i] = wr && (word == AW'(i));

      opb_status_chan #(.STICKY_MASK(C_STICKY_MASK)) u_chan (
         .clk       (OPB_Clk),
         .rst       (OPB_Rst),
         .valid     (user_valid[i]),
         .din       (user_data_in[STATUS_W*i +: STATUS_W]),
         .clr_en    (chan_wr[i]),
         .clr_data  (wdata),
         .clr_mask  (wmask),
`ifdef OPB_STATUS_BANK_TIMESTAMP_EN
         .ts_now    (ts_count),
         .ts        (ts[i]),
`endif
         .status    (status[i]),
         .pending_c (pending[i])
      );
   end

   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst)
         irq_en <= '0;
      else if (wr && word == AW'(irq_en_word(C_NUM_CH)))
         irq_en <= (irq_en & ~wmask[C_NUM_CH-1:0]) | (wdata[C_NUM_CH-1:0] & wmask[C_NUM_CH-1:0]);
   end

   // Read mux; unmapped in-window words fall through to zero.
   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < C_NUM_CH; i++)
         if (word == AW'(i)) rdata = status[i];
      if (word == AW'(pending_word(C_NUM_CH))) rdata = STATUS_W'(pending);
      if (word == AW'(irq_en_word(C_NUM_CH)))  rdata = STATUS_W'(irq_en);
`ifdef OPB_STATUS_BANK_TIMESTAMP_EN
      for (int unsigned i = 0; i < C_NUM_CH; i++)
         if (word == AW'(ts_base_word(C_NUM_CH) + i)) rdata = ts[i];
`endif
   end

   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         Sl_xferAck <= 1'b0;
         Sl_DBus    <= '0;
         irq        <= 1'b0;
      end else begin
         Sl_xferAck <= start;
         Sl_DBus    <= (start && OPB_RNW) ? reg_to_bus(rdata) : '0;
         irq        <= |(pending & irq_en);
      end
   end

endmodule

// File: tb/tb_opb_status_bank.sv
// Self-checking bench for opb_status_bank: directed table, corner sequences and a randomized model check.
module tb_opb_status_bank;

   localparam logic [31:0] BASE   = 32'h0100_2100;
   localparam logic [31:0] HIGH   = 32'h0100_21FF;
   localparam int          N      = 4;
   localparam logic [31:0] STICKY = 32'h0000_00FF;

   typedef enum logic [1:0] {OP_STROBE, OP_WRITE, OP_READ} op_e;
   typedef struct {
      op_e         op;
      logic [31:0] off;
      logic [31:0] data;
      logic [0:3]  be;
      logic [31:0] exp;
      logic        exp_irq;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [0:31]    abus;
   logic [0:3]     be;
   logic [0:31]    dbus;
   logic           rnw, sel, seq;
   logic [0:31]    sl_dbus;
   logic           ack, errack, retry, tout;
   logic [N*32-1:0] udata;
   logic [N-1:0]   uvalid;
   logic           irq;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   logic [31:0] m_status [N];
   logic [N-1:0] m_irq_en;

   always #5 clk = ~clk;
   always @(posedge clk or posedge rst) if (rst) cyc <= 0; else cyc <= cyc + 1;

   opb_status_bank #(.C_NUM_CH(N), .C_STICKY_MASK(STICKY)) dut (
      .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
      .Sl_xferAck(ack), .Sl_errAck(errack), .Sl_retry(retry), .Sl_toutSup(tout),
      .user_data_in(udata), .user_valid(uvalid), .irq(irq));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain statement of the register rules.
   function automatic logic [31:0] be_mask(input logic [0:3] ben);
      logic [31:0] m = '0;
      for (int b = 0; b < 4; b++) if (ben[b]) m[31-8*b -: 8] = 8'hFF;
      return m;
   endfunction

   task automatic m_strobe(input int ch, input logic [31:0] d);
      m_status[ch] = (d & ~STICKY) | ((m_status[ch] | d) & STICKY);
   endtask

   function automatic logic [N-1:0] m_pending();
      logic [N-1:0] p = '0;
      for (int i = 0; i < N; i++) p[i] = ((m_status[i] & STICKY) != 0);
      return p;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] addr);
      int unsigned w = (addr - BASE) >> 2;
      if (w < N)      return m_status[w];
      if (w == N)     return 32'(m_pending());
      if (w == N + 1) return 32'(m_irq_en);
      return 32'h0;
   endfunction

   task automatic do_reset();
      sel = 0; rnw = 1; abus = '0; be = '0; dbus = '0; seq = 0; uvalid = '0; udata = '0;
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < N; i++) m_status[i] = '0;
      m_irq_en = '0;
   endtask

   task automatic strobe(input int ch, input logic [31:0] d);
      uvalid = '0; uvalid[ch] = 1'b1; udata[32*ch +: 32] = d;
      @(posedge clk); #1;
      uvalid = '0;
      m_strobe(ch, d);
      @(posedge clk); #1;
   endtask

   task automatic bus_xfer(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                           input logic [0:3] ben, input logic [N-1:0] v, input logic [N*32-1:0] vd,
                           output logic [31:0] rdata, output logic irq_at_ack);
      int lat = 0;
      logic acked = 1'b0;
      logic inwin;
      int unsigned w;
      logic [31:0] msk;
      inwin = (addr >= BASE) && (addr <= HIGH);
      abus = addr; rnw = ~write; dbus = write ? wdata : 32'h0; be = ben; sel = 1'b1;
      uvalid = v; udata = vd;
      rdata = '0; irq_at_ack = 1'b0;
      while (!acked && lat < 16) begin
         @(posedge clk); #1;
         lat++;
         uvalid = '0;
         if (ack) begin acked = 1'b1; rdata = sl_dbus; irq_at_ack = irq; end
      end
      sel = 0; rnw = 1; dbus = '0; be = '0;
      if (inwin) begin
         check("ack_latency", 32'(lat), 32'd1);
         if (acked && write) begin
            w   = (addr - BASE) >> 2;
            msk = be_mask(ben);
            if (w < N) m_status[w] = m_status[w] & ~(wdata & msk & STICKY);
            else if (w == N + 1) m_irq_en = N'((32'(m_irq_en) & ~msk) | (wdata & msk));
         end
      end else begin
         check("no_ack_outside", 32'(acked), 32'd0);
      end
      for (int i = 0; i < N; i++) if (v[i]) m_strobe(i, vd[32*i +: 32]);
      @(posedge clk); #1;
      check("ack_single_cycle", 32'(ack), 32'd0);
      check("dbus_idle", sl_dbus, 32'h0);
   endtask

   vec_t vecs[$];
   logic [31:0] rd, exp_ts;
   logic ia;
   logic [N*32-1:0] vd;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      check("reset_ack", 32'(ack), 0);
      check("reset_dbus", sl_dbus, 0);
      check("reset_irq", 32'(irq), 0);
      check("tied_outputs", {29'd0, errack, retry, tout}, 0);
      for (int w = 0; w < 64; w++) begin
         bus_xfer(BASE + 32'(4*w), 1'b0, 0, 4'hF, '0, '0, rd, ia);
         check($sformatf("reset_word%0d", w), rd, 32'h0);
      end
      check("reset_irq_after_reads", 32'(irq), 0);

      vecs.push_back('{OP_STROBE, 32'h04, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_STROBE, 32'h04, 32'h0000_0002, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_READ,   32'h04, 32'h0,         4'hF, 32'h0000_0003, 1'b0});
      vecs.push_back('{OP_READ,   32'h10, 32'h0,         4'hF, 32'h0000_0002, 1'b0});
      vecs.push_back('{OP_WRITE,  32'h14, 32'h0000_0002, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_READ,   32'h14, 32'h0,         4'hF, 32'h0000_0002, 1'b1});
      vecs.push_back('{OP_WRITE,  32'h04, 32'h0000_0001, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_READ,   32'h04, 32'h0,         4'hF, 32'h0000_0002, 1'b1});
      vecs.push_back('{OP_WRITE,  32'h04, 32'h0000_0002, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_READ,   32'h04, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
      vecs.push_back('{OP_READ,   32'h10, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
      vecs.push_back('{OP_STROBE, 32'h08, 32'h0000_00FF, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_WRITE,  32'h08, 32'h0000_00FF, 4'b1110, 32'h0, 1'b0});
      vecs.push_back('{OP_READ,   32'h08, 32'h0,         4'hF, 32'h0000_00FF, 1'b0});
      vecs.push_back('{OP_WRITE,  32'h08, 32'h0000_00FF, 4'b0001, 32'h0, 1'b0});
      vecs.push_back('{OP_READ,   32'h08, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
      vecs.push_back('{OP_STROBE, 32'h0C, 32'h1234_5600, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_WRITE,  32'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_READ,   32'h0C, 32'h0,         4'hF, 32'h1234_5600, 1'b0});
      vecs.push_back('{OP_WRITE,  32'h14, 32'h0000_000F, 4'b1110, 32'h0, 1'b0});
      vecs.push_back('{OP_READ,   32'h14, 32'h0,         4'hF, 32'h0000_0002, 1'b0});
      vecs.push_back('{OP_WRITE,  32'h14, 32'h0000_0000, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_WRITE,  32'h28, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0});
      vecs.push_back('{OP_READ,   32'h28, 32'h0,         4'hF, 32'h0000_0000, 1'b0});
      vecs.push_back('{OP_READ,   32'hFC, 32'h0,         4'hF, 32'h0000_0000, 1'b0});

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OP_STROBE: strobe(int'(vecs[i].off >> 2), vecs[i].data);
            OP_WRITE:  bus_xfer(BASE + vecs[i].off, 1'b1, vecs[i].data, vecs[i].be, '0, '0, rd, ia);
            default: begin
               bus_xfer(BASE + vecs[i].off, 1'b0, 0, 4'hF, '0, '0, rd, ia);
               check($sformatf("vec%0d_read", i), rd, vecs[i].exp);
               check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            end
         endcase
      end

      // irq drops one cycle after pending clears
      bus_xfer(BASE + 32'h14, 1'b1, 32'h1, 4'hF, '0, '0, rd, ia);
      strobe(0, 32'h1);
      check("irq_set", 32'(irq), 1);
      bus_xfer(BASE, 1'b1, 32'h1, 4'hF, '0, '0, rd, ia);
      check("irq_lag_at_ack", 32'(ia), 1);
      check("irq_cleared", 32'(irq), 0);

      // same-cycle W1C and set: set wins on bit 0, bit 1 clears
      strobe(0, 32'h3);
      vd = '0; vd[31:0] = 32'h1;
      bus_xfer(BASE, 1'b1, 32'hFF, 4'hF, 4'b0001, vd, rd, ia);
      bus_xfer(BASE, 1'b0, 0, 4'hF, '0, '0, rd, ia);
      check("set_wins", rd, 32'h1);

      // read returns state from before a same-cycle sample
      vd = '0; vd[95:64] = 32'h80;
      bus_xfer(BASE + 32'h08, 1'b0, 0, 4'hF, 4'b0100, vd, rd, ia);
      check("read_before_update", rd, 32'h0);
      bus_xfer(BASE + 32'h08, 1'b0, 0, 4'hF, '0, '0, rd, ia);
      check("read_after_update", rd, 32'h80);

      // outside the window: no ack, no side effect
      bus_xfer(HIGH + 32'd4, 1'b1, 32'hFF, 4'hF, '0, '0, rd, ia);
      bus_xfer(BASE - 32'd4, 1'b0, 0, 4'hF, '0, '0, rd, ia);
      bus_xfer(BASE, 1'b0, 0, 4'hF, '0, '0, rd, ia);
      check("outside_no_effect", rd, 32'h1);
`ifndef OPB_STATUS_BANK_TIMESTAMP_EN
      bus_xfer(BASE + 32'h18, 1'b0, 0, 4'hF, '0, '0, rd, ia);
      check("ts_word_absent", rd, 32'h0);
`endif

      // reset during the ack cycle
      abus = BASE; rnw = 1'b1; sel = 1'b1;
      @(posedge clk); #1;
      check("ack_before_reset", 32'(ack), 1);
      #2 rst = 1'b1;
      #1 check("ack_forced_low", 32'(ack), 0);
      do_reset();
      bus_xfer(BASE, 1'b0, 0, 4'hF, '0, '0, rd, ia);
      check("reset_cleared_ch0", rd, 32'h0);

`ifdef OPB_STATUS_BANK_TIMESTAMP_EN
      do_reset();
      while (cyc < 100) begin @(posedge clk); #1; end
      exp_ts = 32'(cyc);
      strobe(0, 32'h55);
      strobe(0, 32'h55);
      bus_xfer(BASE + 32'h18, 1'b0, 0, 4'hF, '0, '0, rd, ia);
      check("ts_latched", rd, exp_ts);
      check("ts_cycle100", exp_ts, 32'd100);
`endif

      // randomized traffic against the model
      for (int it = 0; it < 400; it++) begin
         int unsigned kind, ch, w;
         logic [31:0] d, addr, exp;
         logic [0:3] rbe;
         kind = $urandom_range(0, 3);
         ch   = $urandom_range(0, N-1);
         d    = $urandom;
         rbe  = 4'($urandom);
         case (kind)
            0: strobe(int'(ch), d);
            1: begin
               vd = '0;
               for (int i = 0; i < N; i++) vd[32*i +: 32] = $urandom;
               bus_xfer(BASE + 32'(4*ch), 1'b1, d, rbe,
                        ($urandom_range(0, 3) == 0) ? N'($urandom) : '0, vd, rd, ia);
            end
            2: bus_xfer(BASE + 32'h14, 1'b1, d, rbe, '0, '0, rd, ia);
            default: begin
               w    = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 63) : $urandom_range(0, 5);
               addr = BASE + 32'(4*w);
               exp  = m_read(addr);
               bus_xfer(addr, 1'b0, 0, 4'hF, '0, '0, rd, ia);
               check($sformatf("rand%0d_word%0d", it, w), rd, exp);
            end
         endcase
         check($sformatf("rand%0d_irq", it), 32'(irq), 32'(|(m_pending() & m_irq_en)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
